aes128_iter_encrypt: RTL and testbench
======================================

Name: aes128_iter_encrypt

Overview:
Iterative AES-128 encryption controller. It sits directly upstream of, and wraps, the existing combinational normalRound stage. It performs the initial AddRoundKey, feeds normalRound one round per clock for rounds 1-9, then runs a final round without MixColumns. It generates the rcon sequence and presents the ciphertext to the consumer through a valid/ready handshake.

Parameters:
none (AES-128 only; Nr fixed at 10, rcon table fixed)

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  plaintext/key presented
in_ready  output  1  block can accept a new job
plaintext  input  128  block to encrypt, byte 0 in [127:120]
key  input  128  cipher key, same byte order
out_valid  output  1  ciphertext valid, held until accepted
out_ready  input  1  consumer accepts ciphertext
ciphertext  output  128  encrypted block, same byte order
busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE, round=0, state_reg=0, key_reg=0, ciphertext=0.
  - out_valid=0, busy=0.
  - in_ready=1 (it is decoded from IDLE, so it is also 1 while rst_n is low).
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge T: state_reg<=plaintext^key, key_reg<=key, round<=1, go RUN.
  - in_valid with in_ready low is ignored. No input buffering.
- RUN, rounds 1-9:
  - normalRound gets data=state_reg, keyin=key_reg, rcon=RCON[round].
  - state_reg<=dataout, key_reg<=keyout, round<=round+1.
- RUN, round 10:
  - aes_final_round (SubBytes, ShiftRows, key expansion, AddRoundKey) output goes to ciphertext.
  - out_valid<=1, go DONE.
- rcon format: {rc,24'h0}. rc for rounds 1..10 = 01,02,04,08,10,20,40,80,1b,36. The round counter is 4 bits, and values 0 and 11-15 map to rcon 0.
- Latency: out_valid rises at edge T+10 after acceptance at edge T. No mid-run handshake or stall.
- DONE:
  - out_valid=1; ciphertext is stable and must not change while out_valid=1 && !out_ready.
  - On out_ready: out_valid<=0, go IDLE, in_ready=1 next cycle.
  - Throughput: one block per 12 cycles minimum.
- Simultaneous events:
  - out_ready and in_valid in the same cycle in DONE: only the output is accepted. The input is not taken, because in_ready=0.
  - out_ready while out_valid=0 is ignored.
- Reset mid-operation: asynchronous assertion aborts the job immediately. No output is produced for it, and all registers return to reset values.
- Data path is registered state_reg/key_reg only. Combinational round logic comes from the existing submodules. The $display inside normalRound is tolerated in simulation.

Decomposition:
- Shared package aes_pkg:
  - rcon table function/constant (10 entries, {rc,24'h0});
  - NR=10;
  - FSM state enum {IDLE,RUN,DONE}.
- One new sub-module, aes_final_round(rcon, keyin, data, keyout, dataout). It reuses the existing key_expansion, subBytes and shiftRows, omits mixColumns, and XORs with keyout.
- One normalRound instance is reused each RUN cycle.

Test Plan:
1. FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ciphertext 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 cycles after the accept edge.
2. FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
3. Backpressure: hold out_ready=0 for 20 cycles after vector 1 -> out_valid stays 1, ciphertext unchanged, in_ready stays 0, and a second in_valid is ignored.
4. Back-to-back: apply vectors 1 and 2 with in_valid held high and out_ready=1 -> two correct ciphertexts in order, second accept exactly one cycle after the first DONE handshake.
5. Reset mid-run: assert rst_n=0 at round 5 for 1 cycle -> out_valid=0, ciphertext=0, in_ready=1 immediately; a subsequent vector 2 encrypts correctly.
6. rcon check: probe the rcon fed each RUN cycle -> sequence 01000000..36000000 for rounds 1..10.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, rcon table, FSM states, GF(2^8) helpers.
// Pure combinational functions; no state.
// Used by the iterative encryptor and its round sub-modules.
package aes_pkg;

  localparam logic [3:0] NR = 4'd10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} aes_state_e;

  // rcon word for a round number; round 0 and anything past 10 give zero
  function automatic logic [31:0] rcon_of(input logic [3:0] round);
    logic [7:0] rc;
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h0};
  endfunction

  // multiply by x modulo the AES polynomial
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as inverse (a^254, which maps 0 to 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] r;
    p = b;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes128_iter_encrypt_if.sv
// Job/result handshake bundle between an encryption client and the encryptor.
// No logic; master drives the job and result-accept, slave answers.
// Input side is valid/ready, output side is valid/ready with data held.
interface aes128_iter_encrypt_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;

  modport master (
    output in_valid, plaintext, key, out_ready,
    input  in_ready, out_valid, ciphertext, busy
  );

  modport slave (
    input  in_valid, plaintext, key, out_ready,
    output in_ready, out_valid, ciphertext, busy
  );
endinterface

// File: rtl/aes_final_round.sv
// Last AES round: SubBytes, ShiftRows, AddRoundKey; MixColumns is skipped.
// Combinational, zero latency.
// No flow control.
module aes_final_round (
  input  logic [31:0]  rcon,
  input  logic [127:0] keyin,
  input  logic [127:0] data,
  output logic [127:0] keyout,
  output logic [127:0] dataout
);
  logic [127:0] sb, sr;

  key_expansion u_key (.rcon(rcon), .keyin(keyin), .keyout(keyout));
  subBytes      u_sb  (.din(data), .dout(sb));
  shiftRows     u_sr  (.din(sb),   .dout(sr));

  assign dataout = sr ^ keyout;
endmodule

// File: rtl/key_expansion.sv
// One step of the AES-128 key schedule: previous round key to next round key.
// Combinational, zero latency.
// No flow control.
module key_expansion
  import aes_pkg::*;
(
  input  logic [31:0]  rcon,
  input  logic [127:0] keyin,
  output logic [127:0] keyout
);
  logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;

  assign w0 = keyin[127:96];
  assign w1 = keyin[95:64];
  assign w2 = keyin[63:32];
  assign w3 = keyin[31:0];

  // SubWord(RotWord(w3)) xor rcon
  assign t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ rcon;

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign keyout = {n0, n1, n2, n3};
endmodule

// File: rtl/mixColumns.sv
// MixColumns on each 32-bit column of the state.
// Combinational, zero latency.
// No flow control.
module mixColumns
  import aes_pkg::*;
(
  input  logic [127:0] din,
  output logic [127:0] dout
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = din[127-32*c -: 8];
    assign a1 = din[119-32*c -: 8];
    assign a2 = din[111-32*c -: 8];
    assign a3 = din[103-32*c -: 8];
    assign dout[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign dout[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign dout[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign dout[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end
endmodule

// File: rtl/normalRound.sv
// Full AES round: SubBytes, ShiftRows, MixColumns, AddRoundKey with the expanded key.
// Combinational, zero latency.
// No flow control.
module normalRound (
  input  logic [31:0]  rcon,
  input  logic [127:0] keyin,
  input  logic [127:0] data,
  output logic [127:0] keyout,
  output logic [127:0] dataout
);
  logic [127:0] sb, sr, mc;

  key_expansion u_key (.rcon(rcon), .keyin(keyin), .keyout(keyout));
  subBytes      u_sb  (.din(data), .dout(sb));
  shiftRows     u_sr  (.din(sb),   .dout(sr));
  mixColumns    u_mc  (.din(sr),   .dout(mc));

  assign dataout = mc ^ keyout;
endmodule

// File: rtl/shiftRows.sv
// ShiftRows: row r rotates left by r columns; byte i sits at row i%4, column i/4.
// Combinational, zero latency.
// No flow control.
module shiftRows (
  input  logic [127:0] din,
  output logic [127:0] dout
);
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign dout[127-8*(r+4*c) -: 8] = din[127-8*(r+4*((c+r)%4)) -: 8];
    end
  end
endmodule

// File: rtl/subBytes.sv
// SubBytes over all 16 bytes of the state.
// Combinational, zero latency.
// No flow control.
module subBytes
  import aes_pkg::*;
(
  input  logic [127:0] din,
  output logic [127:0] dout
);
  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign dout[127-8*i -: 8] = sbox(din[127-8*i -: 8]);
  end
endmodule

// File: rtl/aes128_iter_encrypt.sv
// Iterative AES-128 encryptor: initial AddRoundKey at accept, then one round per clock.
// Latency: out_valid rises 10 edges after the accept edge; at best one job per 12 cycles.
// Backpressure: in_ready only in IDLE; ciphertext and out_valid held until out_ready.
module aes128_iter_encrypt
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  aes128_iter_encrypt_if.slave bus
);
  aes_state_e   state;
  logic [3:0]   round;
  logic [127:0] state_reg;
  logic [127:0] key_reg;
  logic [127:0] ct_reg;
  logic         out_valid_r;
  logic [31:0]  rcon_cur;
  logic [127:0] nr_data, nr_key;
  logic [127:0] fr_data, fr_key;

  // round counter is zero outside RUN, so rcon is zero there too
  assign rcon_cur = rcon_of(round);

  normalRound u_round (
    .rcon    (rcon_cur),
    .keyin   (key_reg),
    .data    (state_reg),
    .keyout  (nr_key),
    .dataout (nr_data)
  );

  aes_final_round u_final (
    .rcon    (rcon_cur),
    .keyin   (key_reg),
    .data    (state_reg),
    .keyout  (fr_key),
    .dataout (fr_data)
  );

  assign bus.in_ready   = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.out_valid  = out_valid_r;
  assign bus.ciphertext = ct_reg;

  // control FSM and the registered datapath; no stall once a job is running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      round       <= 4'd0;
      state_reg   <= '0;
      key_reg     <= '0;
      ct_reg      <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state_reg <= bus.plaintext ^ bus.key;
            key_reg   <= bus.key;
            round     <= 4'd1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (round == NR) begin
            ct_reg      <= fr_data;
            key_reg     <= fr_key;
            round       <= 4'd0;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            state_reg <= nr_data;
            key_reg   <= nr_key;
            round     <= round + 4'd1;
          end
        end
        DONE: begin
          // a new job cannot be taken on the same edge: in_ready is low here
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          round       <= 4'd0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes128_iter_encrypt.sv
// Directed bench for the iterative AES-128 encryptor using FIPS-197 vectors.
// Checks latency, rcon sequence, backpressure hold, back-to-back and mid-run reset.
// Inputs driven #1 after rising edges; outputs sampled at the same point.
module tb_aes128_iter_encrypt;
  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   cyc;
  logic [31:0] rc_seen [10];
  logic [31:0] rc_exp  [10] = '{32'h01000000, 32'h02000000, 32'h04000000, 32'h08000000,
                                32'h10000000, 32'h20000000, 32'h40000000, 32'h80000000,
                                32'h1b000000, 32'h36000000};

  aes128_iter_encrypt_if bus ();

  aes128_iter_encrypt dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // wait for out_valid after an accept edge, logging rcon of each RUN cycle
  task automatic wait_out(output int n);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      if (n < 10) rc_seen[n] = dut.rcon_cur;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic apply_and_wait(input logic [127:0] pt, input logic [127:0] k, output int n);
    bus.plaintext = pt;
    bus.key       = k;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    wait_out(n);
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_eq({tag, "_ov_drop"}, 128'(bus.out_valid), 128'd0);
    check_eq({tag, "_idle"},    128'(bus.in_ready),  128'd1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.plaintext = '0;
    bus.key       = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 128'(bus.in_ready),  128'd1);
    check_eq("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check_eq("rst_busy",     128'(bus.busy),      128'd0);
    check_eq("rst_ct",       bus.ciphertext,      128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 App. B with latency and rcon sequence
    apply_and_wait(PT1, K1, cyc);
    check_eq("v1_latency", 128'(cyc), 128'd10);
    check_eq("v1_ct", bus.ciphertext, CT1);
    for (int i = 0; i < 10; i++)
      check_eq($sformatf("rcon_r%0d", i + 1), 128'(rc_seen[i]), 128'(rc_exp[i]));

    // backpressure: result held, new job refused
    bus.plaintext = PT2;
    bus.key       = K2;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check_eq("bp_out_valid", 128'(bus.out_valid), 128'd1);
      check_eq("bp_ct",        bus.ciphertext,      CT1);
      check_eq("bp_in_ready",  128'(bus.in_ready),  128'd0);
    end
    bus.in_valid = 1'b0;
    drain("bp");
    check_eq("bp_not_taken", 128'(bus.busy), 128'd0);

    // FIPS-197 App. C.1
    apply_and_wait(PT2, K2, cyc);
    check_eq("v2_latency", 128'(cyc), 128'd10);
    check_eq("v2_ct", bus.ciphertext, CT2);
    drain("v2");

    // back-to-back with in_valid held and out_ready high
    bus.out_ready = 1'b1;
    bus.plaintext = PT1;
    bus.key       = K1;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    wait_out(cyc);
    check_eq("b2b1_latency", 128'(cyc), 128'd10);
    check_eq("b2b1_ct", bus.ciphertext, CT1);
    bus.plaintext = PT2;
    bus.key       = K2;
    @(posedge clk); #1;
    check_eq("b2b_hs_ov",    128'(bus.out_valid), 128'd0);
    check_eq("b2b_hs_ready", 128'(bus.in_ready),  128'd1);
    @(posedge clk); #1;
    check_eq("b2b_acc_busy",  128'(bus.busy),     128'd1);
    check_eq("b2b_acc_ready", 128'(bus.in_ready), 128'd0);
    bus.in_valid = 1'b0;
    wait_out(cyc);
    check_eq("b2b2_latency", 128'(cyc), 128'd10);
    check_eq("b2b2_ct", bus.ciphertext, CT2);
    @(posedge clk); #1;
    check_eq("b2b2_ov_drop", 128'(bus.out_valid), 128'd0);
    bus.out_ready = 1'b0;

    // reset in round 5 aborts the job
    bus.plaintext = PT1;
    bus.key       = K1;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("mr_round5_rcon", 128'(dut.rcon_cur), 128'h10000000);
    rst_n = 1'b0;
    #1;
    check_eq("mr_ov",    128'(bus.out_valid), 128'd0);
    check_eq("mr_ct",    bus.ciphertext,      128'd0);
    check_eq("mr_ready", 128'(bus.in_ready),  128'd1);
    check_eq("mr_busy",  128'(bus.busy),      128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check_eq("mr_no_output", 128'(bus.out_valid), 128'd0);
    apply_and_wait(PT2, K2, cyc);
    check_eq("mr_v2_latency", 128'(cyc), 128'd10);
    check_eq("mr_v2_ct", bus.ciphertext, CT2);
    drain("mr");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
